// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: MIPS core has default priority, the external master
// gets bounded-latency access via a starvation counter and capped bursts.
module mem_arbiter #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic          ext_last,
  input  logic [AW-1:0] ext_adr,
  input  logic [DW-1:0] ext_wd,
  output logic [DW-1:0] ext_rd,
  output logic          ext_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int unsigned SW       = $clog2(STARVE_MAX + 1);
  localparam int unsigned BW       = $clog2(BURST_MAX + 1);
  localparam bit          BURST_EN = (BURST_MAX > 1);

  typedef enum logic {
    S_CPU = 1'b0,
    S_EXT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          grant_ext;
  logic          starved;
  logic          burst_full;

  assign starved    = (starve_q == SW'(STARVE_MAX));
  assign burst_full = ((beat_q + BW'(1)) == BW'(BURST_MAX));

  // Grant is forced off while reset is held so nothing reaches memory mid-reset.
  always_comb begin
    grant_ext = 1'b0;
    if (reset) begin
      case (state_q)
        S_CPU:   grant_ext = ext_req & (~cpu_req | starved);
        S_EXT:   grant_ext = ext_req;
        default: grant_ext = 1'b0;
      endcase
    end
  end

  assign ext_ack   = grant_ext;
  assign cpu_stall = cpu_req & grant_ext;
  assign cpu_rd    = mem_rd;
  assign ext_rd    = mem_rd;

  always_comb begin
    if (grant_ext) begin
      mem_we  = ext_we;
      mem_adr = ext_adr;
      mem_wd  = ext_wd;
    end else begin
      mem_we  = reset & cpu_req & cpu_we;
      mem_adr = cpu_adr;
      mem_wd  = cpu_wd;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!ext_req || grant_ext) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_CPU: begin
        if (grant_ext && !ext_last && BURST_EN) begin
          state_d = S_EXT;
          beat_d  = BW'(1);
        end
      end
      S_EXT: begin
        // An abandoned burst (ext_req low) also falls back to the core.
        if (!ext_req || ext_last || burst_full) begin
          state_d = S_CPU;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + BW'(1);
        end
      end
      default: begin
        state_d = S_CPU;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_CPU;
      starve_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a combinational-read / edge-write memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_adr, cpu_wd, cpu_rd;
  logic        cpu_stall;
  logic        ext_req, ext_we, ext_last;
  logic [31:0] ext_adr, ext_wd, ext_rd;
  logic        ext_ack;
  logic        mem_we;
  logic [31:0] mem_adr, mem_wd, mem_rd;

  logic [31:0] mem [0:255];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mem_arbiter #(.DW(32), .AW(32), .STARVE_MAX(8), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_last(ext_last), .ext_adr(ext_adr),
    .ext_wd(ext_wd), .ext_rd(ext_rd), .ext_ack(ext_ack),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_adr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_adr[9:2]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; ext_req = 0; ext_we = 0; ext_last = 0;
  endtask

  task automatic cpu_read_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    idle();
    cpu_req = 1; cpu_adr = adr;
    #1;
    chk(tag, cpu_rd, exp);
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 0; cpu_adr = '0; cpu_wd = '0; ext_adr = '0; ext_wd = '0;
    idle();

    // During reset, all grants are forced off
    #2;
    cpu_req = 1; cpu_we = 1; ext_req = 1; ext_we = 1;
    #1;
    chk("rst_ack", ext_ack, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_we", mem_we, 0);
    cyc();
    idle();
    cyc();
    reset = 1;
    #1;
    chk("rst_state", 32'(dut.state_q), 0);
    chk("rst_starve", dut.starve_q, 0);
    chk("rst_beat", dut.beat_q, 0);

    // Idle: no requests
    cpu_adr = 32'h123;
    #1;
    chk("idle_we", mem_we, 0);
    chk("idle_adr", mem_adr, 32'h123);
    chk("idle_ack", ext_ack, 0);
    chk("idle_stall", cpu_stall, 0);
    cyc();

    // Core only: write then read back
    cpu_req = 1; cpu_we = 1; cpu_adr = 32'h40; cpu_wd = 32'hDEADBEEF;
    #1;
    chk("core_wr_stall", cpu_stall, 0);
    chk("core_wr_ack", ext_ack, 0);
    chk("core_wr_we", mem_we, 1);
    cyc();
    cpu_we = 0;
    #1;
    chk("core_rd_stall", cpu_stall, 0);
    chk("core_rd_data", cpu_rd, 32'hDEADBEEF);
    chk("core_rd_ack", ext_ack, 0);
    cyc();

    // Starvation: grant on every 9th cycle
    cpu_req = 1; cpu_we = 0; cpu_adr = 32'h40;
    ext_req = 1; ext_last = 1; ext_we = 0; ext_adr = 32'h80;
    for (int c = 0; c < 18; c++) begin
      #1;
      chk($sformatf("starve_ack_c%0d", c), ext_ack, (c % 9 == 8) ? 1 : 0);
      chk($sformatf("starve_stall_c%0d", c), cpu_stall, (c % 9 == 8) ? 1 : 0);
      if (c == 8) chk("starve_adr", mem_adr, 32'h80);
      cyc();
    end
    idle();
    cyc();

    // Burst cap: six writes, four per grant, core slips in between
    ext_req = 1; ext_we = 1;
    for (int k = 0; k < 4; k++) begin
      ext_adr = 32'h100 + 32'(4 * k); ext_wd = 32'hA000_0000 + 32'(k); ext_last = 0;
      #1;
      chk($sformatf("burst_ack_b%0d", k), ext_ack, 1);
      cyc();
    end
    cpu_req = 1; cpu_adr = 32'h100;
    ext_adr = 32'h110; ext_wd = 32'hA000_0004;
    #1;
    chk("burst_core_ack", ext_ack, 0);
    chk("burst_core_stall", cpu_stall, 0);
    chk("burst_core_rd", cpu_rd, 32'hA000_0000);
    cyc();
    cpu_req = 0;
    #1;
    chk("burst_ack_b4", ext_ack, 1);
    cyc();
    ext_adr = 32'h114; ext_wd = 32'hA000_0005; ext_last = 1;
    #1;
    chk("burst_ack_b5", ext_ack, 1);
    cyc();
    for (int k = 0; k < 6; k++)
      cpu_read_chk($sformatf("burst_mem_%0d", k), 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k));

    // Burst abort, then a fresh burst lasts exactly four beats
    idle();
    ext_req = 1; ext_we = 1; ext_adr = 32'h200; ext_wd = 32'hB0;
    #1;
    chk("abort_b1_ack", ext_ack, 1);
    cyc();
    cpu_req = 1; ext_adr = 32'h204; ext_wd = 32'hB1;
    #1;
    chk("abort_b2_ack", ext_ack, 1);
    chk("abort_b2_stall", cpu_stall, 1);
    cyc();
    ext_req = 0; ext_we = 0; cpu_we = 1; cpu_adr = 32'h208; cpu_wd = 32'h55;
    #1;
    chk("abort_stall", cpu_stall, 0);
    chk("abort_we", mem_we, 1);
    chk("abort_adr", mem_adr, 32'h208);
    cyc();
    cpu_we = 0; ext_req = 1;
    #1;
    chk("abort_cpu_state_ack", ext_ack, 0);
    cyc();
    cpu_req = 0; ext_adr = 32'h20C;
    #1;
    chk("fresh_b1_ack", ext_ack, 1);
    cyc();
    cpu_req = 1;
    for (int k = 2; k <= 4; k++) begin
      #1;
      chk($sformatf("fresh_b%0d_stall", k), cpu_stall, 1);
      cyc();
    end
    #1;
    chk("fresh_end_ack", ext_ack, 0);
    cyc();
    idle();
    cyc();
    cpu_read_chk("abort_mem_cpu", 32'h208, 32'h55);

    // Reset mid-burst
    idle();
    cpu_req = 1; cpu_we = 1; cpu_adr = 32'h300; cpu_wd = 32'h1111_1111;
    cyc();
    idle();
    ext_req = 1; ext_we = 1; ext_adr = 32'h2F0; ext_wd = 32'h99;
    #1;
    chk("rstb_b1_ack", ext_ack, 1);
    cyc();
    ext_adr = 32'h300; ext_wd = 32'h2222_2222;
    reset = 0;
    #1;
    chk("rstb_ack", ext_ack, 0);
    chk("rstb_we", mem_we, 0);
    chk("rstb_stall", cpu_stall, 0);
    cyc();
    chk("rstb_state", 32'(dut.state_q), 0);
    chk("rstb_starve", dut.starve_q, 0);
    chk("rstb_beat", dut.beat_q, 0);
    idle();
    reset = 1;
    cyc();
    cpu_read_chk("rstb_mem", 32'h300, 32'h1111_1111);
    idle();
    cpu_req = 1; ext_req = 1; ext_last = 1;
    #1;
    chk("rstb_core_wins", ext_ack, 0);
    cyc();
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the multi-cycle MIPS core and an external master (program loader / debug DMA). Sits between the core's memory port and the unified instruction/data memory, which has a combinational read and a clock-edge write. The core has default priority. The external master gets bounded-latency access through a starvation counter, and bursts are capped so core stalls stay bounded. The core's controller holds all state-enable strobes (pcen, irwrite, regwrite, memwrite) while `cpu_stall` is high.

## Interface
- `DW`, 32, data width
- `AW`, 32, address width
- `STARVE_MAX`, 8, cycles an external request may be denied before access is forced (≥1)
- `BURST_MAX`, 4, maximum consecutive external beats per grant (≥1)

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `cpu_req` in 1: core memory access this cycle
- `cpu_we` in 1: core write
- `cpu_adr` in AW: core address
- `cpu_wd` in DW: core write data
- `cpu_rd` out DW: read data to core (= `mem_rd`)
- `cpu_stall` out 1: core access not served this cycle
- `ext_req` in 1: external access this cycle
- `ext_we` in 1: external write
- `ext_last` in 1: current external beat is the last of its burst
- `ext_adr` in AW: external address
- `ext_wd` in DW: external write data
- `ext_rd` out DW: read data to external master (= `mem_rd`)
- `ext_ack` out 1: external beat served this cycle
- `mem_we` out 1: memory write enable
- `mem_adr` out AW: memory address
- `mem_wd` out DW: memory write data
- `mem_rd` in DW: memory read data, combinational from `mem_adr`

## Operation
- Registered state: `state` ∈ {S_CPU, S_EXT}, `starve_cnt` (clog2(STARVE_MAX+1) bits, saturating), `beat_cnt` (clog2(BURST_MAX+1) bits).
- `grant_ext` is combinational from the registered state and the current requests:
  - In S_CPU: `grant_ext = ext_req & (~cpu_req | starve_cnt == STARVE_MAX)`.
  - In S_EXT: `grant_ext = ext_req`.
- `ext_ack = grant_ext`.
- `cpu_stall = cpu_req & grant_ext`.
- Mux: when `grant_ext` is high, memory is driven from the ext_* fields with `mem_we = ext_we`. Otherwise it is driven from the cpu_* fields with `mem_we = cpu_req & cpu_we`.
- `starve_cnt` update:
  - Cleared on any cycle with `grant_ext`.
  - Incremented, saturating at STARVE_MAX, when `ext_req & ~grant_ext`.
  - Cleared when `ext_req` is low.
- S_CPU transitions:
  - `grant_ext & ~ext_last & BURST_MAX > 1` → S_EXT, `beat_cnt := 1`.
  - Otherwise stay in S_CPU.
- S_EXT transitions:
  - Granted beat with `ext_last`, or with `beat_cnt + 1 == BURST_MAX` → S_CPU, `beat_cnt := 0`.
  - Granted beat otherwise → stay in S_EXT, `beat_cnt += 1`.
  - `ext_req` low (burst abandoned) → S_CPU that cycle. The core is served combinationally in that same cycle.
- With `BURST_MAX = 1`, S_EXT is never entered.
- With no requests: `mem_we = 0`, `mem_adr = cpu_adr`, and both `ext_ack` and `cpu_stall` are 0.

## Timing
- Grant, ack, stall and muxing are zero-latency combinational paths from the requests and the registered state.
- A served read returns data in the same cycle. A served write commits at the next rising edge.
- State and counters update on the rising edge.
- Worst-case external wait under continuous `cpu_req`: STARVE_MAX denied cycles, then granted.
- Worst-case consecutive core stall: BURST_MAX cycles.
- Reset values: `state = S_CPU`, `starve_cnt = 0`, `beat_cnt = 0`.
- While `reset` is low, grants are forced off: `ext_ack = 0`, `cpu_stall = 0`, `mem_we = 0`.
- Reset asserted mid-burst aborts the burst immediately. No write reaches memory at the edge where reset is low.
- Simultaneous `cpu_req` and `ext_req` in S_CPU with `starve_cnt < STARVE_MAX`: the core wins.
- In S_EXT, the core always loses while `ext_req` is high.

## Test plan
- Core only: `cpu_req = 1`, write 0xDEADBEEF to 0x40, then read 0x40 → `cpu_stall = 0` on both cycles, `cpu_rd = 0xDEADBEEF`, `ext_ack = 0`.
- Starvation: `cpu_req` and `ext_req` held high from cycle 0, `ext_last = 1` → `ext_ack` low on cycles 0–7 and high on cycle 8 with `cpu_stall = 1`. Core is served again on cycle 9, and the pattern repeats every 9 cycles.
- Burst cap: `cpu_req = 0`, ext burst of 6 writes with `ext_last` only on beat 6 → 4 beats in S_EXT. Then `cpu_req = 1` for one cycle shows the core winning while `starve_cnt < 8`, and the remaining beats resume. All 6 addresses hold the written data.
- Burst abort: in S_EXT after beat 2, drop `ext_req` with `cpu_req = 1` → core served that same cycle and state returns to S_CPU. The next `ext_req` starts a fresh burst with `beat_cnt = 1`.
- Reset mid-burst: assert `reset` low during external beat 2 with `ext_we = 1` → `ext_ack = 0` and `mem_we = 0` immediately, and the target word is unchanged. After release the state is S_CPU with both counters at 0.
